// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: drives the select (x) and enable (en) inputs of a
// 2^SEL_W-output decoder. It steps x through channels 0..last_sel. Each
// channel holds en high for a programmable dwell and is followed by an
// optional en-low blanking gap. After last_sel it wraps back to channel 0.
// Optional macro SCAN_ONESHOT_EN adds the oneshot input (single sweep) and
// the done output (one-cycle pulse on every IDLE entry from a scan).
module decoder_scan_ctrl #(
   parameter int SEL_W        = 3,
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [SEL_W-1:0]   last_sel,
`ifdef SCAN_ONESHOT_EN
   input  logic               oneshot,
   output logic               done,
`endif
   output logic [SEL_W-1:0]   x,
   output logic               en,
   output logic               busy,
   output logic               wrap_pulse
);

   localparam int BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam int BLANK_LOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

   typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

   state_t             state, state_n;
   logic [SEL_W-1:0]   x_n;
   logic               en_n, busy_n, wrap_n;
   logic               stop_pending, stop_pending_n;
   logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_n;
   logic [BLANK_W-1:0] blank_cnt, blank_cnt_n;

   // Scan configuration captured on an accepted start
   logic [DWELL_W-1:0] dwell_lat;
   logic [SEL_W-1:0]   last_lat;

   logic               to_idle, advance, stop_now, at_last, sweep_end;
   logic [DWELL_W-1:0] dwell_m1;
   logic [SEL_W-1:0]   next_x;

   // A dwell of 0 behaves as 1; the counter holds remaining cycles minus one
   assign dwell_m1 = (dwell == '0) ? '0 : dwell - 1'b1;
   assign stop_now = stop_pending | stop;
   assign at_last  = (x == last_lat);
   assign next_x   = at_last ? '0 : x + 1'b1;

`ifdef SCAN_ONESHOT_EN
   logic oneshot_lat;
   assign sweep_end = oneshot_lat & at_last;
`else
   assign sweep_end = 1'b0;
`endif

   // Latch scan configuration only when a start is accepted in IDLE
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         dwell_lat <= dwell_m1;
         last_lat  <= last_sel;
`ifdef SCAN_ONESHOT_EN
         oneshot_lat <= oneshot;
`endif
      end
   end

   // Next-state and registered-output values for the scan sequencer
   always_comb begin
      state_n        = state;
      x_n            = x;
      en_n           = en;
      busy_n         = busy;
      wrap_n         = 1'b0;
      stop_pending_n = stop_pending;
      dwell_cnt_n    = dwell_cnt;
      blank_cnt_n    = blank_cnt;
      to_idle        = 1'b0;
      advance        = 1'b0;
      case (state)
         IDLE: begin
            // stop is meaningless here, so start wins even if both are high
            if (start) begin
               state_n        = DWELL;
               x_n            = '0;
               en_n           = 1'b1;
               busy_n         = 1'b1;
               dwell_cnt_n    = dwell_m1;
               stop_pending_n = 1'b0;
            end
         end
         DWELL: begin
            if (stop) stop_pending_n = 1'b1;
            // A stop never shortens the dwell; it is acted on at its end
            if (dwell_cnt != '0) begin
               dwell_cnt_n = dwell_cnt - 1'b1;
            end else if (stop_now || sweep_end) begin
               to_idle = 1'b1;
            end else if (BLANK_CYCLES > 0) begin
               state_n     = BLANK;
               en_n        = 1'b0;
               blank_cnt_n = BLANK_W'(BLANK_LOAD);
            end else begin
               advance = 1'b1;
            end
         end
         BLANK: begin
            if (stop) stop_pending_n = 1'b1;
            if (blank_cnt != '0) begin
               blank_cnt_n = blank_cnt - 1'b1;
            end else if (stop_now) begin
               to_idle = 1'b1;
            end else begin
               advance = 1'b1;
            end
         end
         default: to_idle = 1'b1;
      endcase
      // Move to the next channel; wrapping from last_sel flags wrap_pulse
      if (advance) begin
         state_n     = DWELL;
         x_n         = next_x;
         en_n        = 1'b1;
         wrap_n      = at_last;
         dwell_cnt_n = dwell_lat;
      end
      if (to_idle) begin
         state_n        = IDLE;
         x_n            = '0;
         en_n           = 1'b0;
         busy_n         = 1'b0;
         stop_pending_n = 1'b0;
         dwell_cnt_n    = '0;
         blank_cnt_n    = '0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         x            <= '0;
         en           <= 1'b0;
         busy         <= 1'b0;
         wrap_pulse   <= 1'b0;
         stop_pending <= 1'b0;
         dwell_cnt    <= '0;
         blank_cnt    <= '0;
      end else begin
         state        <= state_n;
         x            <= x_n;
         en           <= en_n;
         busy         <= busy_n;
         wrap_pulse   <= wrap_n;
         stop_pending <= stop_pending_n;
         dwell_cnt    <= dwell_cnt_n;
         blank_cnt    <= blank_cnt_n;
      end
   end

`ifdef SCAN_ONESHOT_EN
   // done pulses on the first IDLE cycle after any scan ends
   always_ff @(posedge clk) begin
      if (rst) done <= 1'b0;
      else     done <= to_idle;
   end
`endif

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 3-to-8 decoder and drives its select (x) and enable (en) inputs.
- Steps x through channels 0..last_sel. Each channel gets a programmable dwell time with en high, followed by an optional blanking gap with en low, then wraps and repeats.
- Used for time-multiplexed one-hot outputs such as display digit scanning and LED walking.

Parameters:
- SEL_W, 3: width of x; the decoder has 2^SEL_W outputs.
- DWELL_W, 8: width of the dwell-count input.
- BLANK_CYCLES, 1: number of en-low cycles between channels. 0 means no gap.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin scanning; honoured only in IDLE.
- stop  in  1  one-cycle request to end scanning; honoured only while busy.
- dwell  in  DWELL_W  cycles en stays high per channel; 0 is treated as 1; latched on accepted start.
- last_sel  in  SEL_W  highest channel index scanned; latched on accepted start.
- x  out  SEL_W  select to the decoder.
- en  out  1  enable to the decoder.
- busy  out  1  high in any state except IDLE.
- wrap_pulse  out  1  one-cycle pulse when x wraps from last_sel to 0.

Behaviour:
- Reset: synchronous, active-high. On any clk edge with rst=1: state to IDLE, x=0, en=0, busy=0, wrap_pulse=0, stop_pending=0, dwell and blank counters to 0. Reset mid-scan aborts the scan immediately, with no drain.
- All outputs are registered.
- States: IDLE, DWELL, BLANK.
- IDLE:
  - x=0, en=0, busy=0.
  - start=1 latches dwell and last_sel. The next cycle is DWELL with x=0, en=1, busy=1.
  - start=1 and stop=1 in the same cycle: start is accepted and stop is ignored, because stop only has meaning while busy.
- DWELL:
  - en=1, x holds.
  - en stays high for exactly max(dwell,1) consecutive cycles.
  - After the last dwell cycle:
    - stop_pending=1: next state is IDLE (en=0, x=0, busy=0 next cycle).
    - else BLANK_CYCLES>0: next state is BLANK.
    - else: next state is DWELL on the next channel, with en continuously high.
- BLANK:
  - en=0, x holds the previous channel.
  - Lasts BLANK_CYCLES cycles, then goes to DWELL on the next channel.
  - stop_pending=1 on entry to BLANK, or stop arriving during BLANK: the stop completes at the end of BLANK, to IDLE.
- Next channel:
  - x+1 if x<last_sel, else 0.
  - The move from last_sel to 0 asserts wrap_pulse for one cycle, coincident with the first DWELL cycle of channel 0.
  - The initial entry from IDLE does not pulse wrap_pulse.
- last_sel=0: x stays 0. wrap_pulse fires at every channel boundary. BLANK gaps still occur.
- stop while busy: sets stop_pending. The current channel always completes its dwell; a stop never truncates a dwell. stop_pending clears on entry to IDLE.
- start while busy: ignored, including the dwell and last_sel inputs.
- Changes on dwell and last_sel after start have no effect until the next accepted start.
- x never exceeds the latched last_sel. Counters never under-flow.

Optional Feature:
- Macro: SCAN_ONESHOT_EN.
- Defined:
  - Adds input port oneshot (1 bit), latched on accepted start.
  - Adds output port done (1 bit, reset 0).
  - With latched oneshot=1, the block performs a single sweep 0..last_sel. After channel last_sel's dwell it goes to IDLE with no trailing BLANK and no wrap_pulse.
  - done pulses for one cycle on the IDLE-entry cycle.
  - A stop also pulses done on IDLE entry.
  - With latched oneshot=0, behaviour matches the macro-undefined case, except that done pulses on every IDLE entry from a scan.
- Undefined: neither port exists. Scanning is continuous until stop or rst.

Test Plan:
- Reset mid-scan: start with dwell=4, last_sel=7; at x=3 assert rst for 1 cycle -> next cycle x=0, en=0, busy=0, wrap_pulse=0. A subsequent start restarts at x=0.
- Basic scan (BLANK_CYCLES=1): dwell=2, last_sel=7 -> the repeating pattern is en high 2 cycles then low 1 cycle per channel, with x=0,1,...,7,0. wrap_pulse is high exactly on the first cycle of x=0 after x=7, with a period of 24 cycles.
- dwell=0 and last_sel=0 -> behaves as dwell=1: x constantly 0, en toggling 1,0, wrap_pulse high every en-high cycle after the first.
- BLANK_CYCLES=0 build, dwell=3, last_sel=2 -> en stays 1 continuously; x is 0,0,0,1,1,1,2,2,2,0,... wrap_pulse is high on the cycle x returns to 0.
- Stop handling: stop asserted on the 1st dwell cycle of x=5 (dwell=4) -> en stays high for all 4 cycles of x=5, then IDLE: x=0, en=0, busy=0. A start asserted while busy earlier in the scan changes nothing.
- SCAN_ONESHOT_EN defined: oneshot=1, dwell=1, last_sel=3 -> x=0..3 each with en high 1 cycle and blanks between. After x=3, IDLE with no wrap_pulse; done is high for exactly 1 cycle; busy falls on the same cycle.
